// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: time-stamps every architectural register write
// (except writes to $zero) and queues it in a show-ahead FIFO drained over
// a valid/ready port. Overflowing events are dropped and counted.
module wb_trace_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wb_regwrite,
  input  logic [ADDR_W-1:0]          wb_rd,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_rd,
  output logic [DATA_W-1:0]          out_data,
  output logic [TS_W-1:0]            out_ts,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  input  logic                       clear_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_count_q, drop_count_d;

  logic qualify, full, pop, push, drop;

  // Classify this cycle's write-back event against the FIFO state.
  always_comb begin
    qualify = wb_regwrite && (wb_rd != '0);
    full    = (count_q == CW'(DEPTH));
    pop     = (count_q != '0) && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push    = qualify && (!full || pop);
    drop    = qualify && full && !pop;
  end

  // Next-state computation for pointers, occupancy, timestamp and drop tracking.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ts_d         = ts_q + TS_W'(1);
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    wr_entry_d   = '{rd: wb_rd, data: wb_data, ts: ts_q};

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Clear first, then a same-cycle drop re-arms the sticky flag.
    if (clear_ovf) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_d != 8'hFF) drop_count_d = drop_count_d + 8'd1;
    end
  end

  // Control and status registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ts_q         <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ts_q         <= ts_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Entry storage write port.
  // NOTE: storage has no reset; stale contents are hidden by masking outputs while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry_d;
  end

  // Show-ahead head entry, forced to zero while the FIFO is empty.
  always_comb begin
    out_valid = (count_q != '0);
    out_rd    = '0;
    out_data  = '0;
    out_ts    = '0;
    if (out_valid) begin
      out_rd   = mem_q[rd_ptr_q].rd;
      out_data = mem_q[rd_ptr_q].data;
      out_ts   = mem_q[rd_ptr_q].ts;
    end
  end

  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_wb_trace_buffer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 16;
  localparam int TS_MOD = 1 << TS_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wb_regwrite = 1'b0;
  logic [ADDR_W-1:0] wb_rd = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_rd;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;
  logic [3:0]        count;
  logic              overflow;
  logic [7:0]        drop_count;
  logic              clear_ovf = 1'b0;

  int total = 0;
  int bad   = 0;
  int edge_idx = 0;

  wb_trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_data(out_data), .out_ts(out_ts),
    .count(count), .overflow(overflow), .drop_count(drop_count),
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int rd; int data; int ts; } ev_t;
  ev_t m_q[$];
  int  m_ts, m_drops;
  bit  m_ovf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_ts = 0; m_drops = 0; m_ovf = 0;
    end else begin
      bit popped, dropped;
      popped  = (m_q.size() > 0) && out_ready;
      dropped = 0;
      if (popped) void'(m_q.pop_front());
      if (wb_regwrite && wb_rd != 0) begin
        if (m_q.size() < DEPTH) m_q.push_back('{rd: int'(wb_rd), data: int'(wb_data), ts: m_ts});
        else dropped = 1;
      end
      if (clear_ovf) begin m_ovf = 0; m_drops = 0; end
      if (dropped) begin m_ovf = 1; if (m_drops < 255) m_drops++; end
      m_ts = (m_ts + 1) % TS_MOD;
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    int e_rd, e_data, e_ts;
    e_rd = 0; e_data = 0; e_ts = 0;
    if (m_q.size() > 0) begin e_rd = m_q[0].rd; e_data = m_q[0].data; e_ts = m_q[0].ts; end
    check("cyc_valid", out_valid, m_q.size() > 0);
    check("cyc_count", count, m_q.size());
    check("cyc_rd", out_rd, e_rd);
    check("cyc_data", out_data, e_data);
    check("cyc_ts", out_ts, e_ts);
    check("cyc_ovf", overflow, m_ovf);
    check("cyc_drops", drop_count, m_drops);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    edge_idx++;
  endtask

  task automatic push_ev(input int rd, input int data);
    wb_regwrite = 1'b1; wb_rd = ADDR_W'(rd); wb_data = DATA_W'(data);
    tick();
    wb_regwrite = 1'b0;
  endtask

  int got_rd [20];
  int got_ts [20];

  task automatic drain(output int n);
    n = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) begin
      got_rd[n] = int'(out_rd);
      got_ts[n] = int'(out_ts);
      n++;
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    // 1: reset then idle
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    edge_idx = 0;
    repeat (3) tick();
    check("idle_valid", out_valid, 1'b0);
    check("idle_count", count, 0);
    check("idle_ovf", overflow, 1'b0);
    check("idle_drops", drop_count, 0);

    // 2: single write captured at ts=5
    repeat (2) tick();
    push_ev(8, 8'h2A);
    check("single_valid", out_valid, 1'b1);
    check("single_rd", out_rd, 8);
    check("single_data", out_data, 8'h2A);
    check("single_ts", out_ts, 5);
    check("single_count", count, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("single_pop_valid", out_valid, 1'b0);
    check("single_pop_count", count, 0);

    // 3: writes to $zero are ignored
    wb_regwrite = 1'b1; wb_rd = '0; wb_data = 8'hFF;
    repeat (4) tick();
    wb_regwrite = 1'b0;
    check("zero_count", count, 0);
    check("zero_drops", drop_count, 0);

    // 4: fill, overflow, in-order drain
    for (int r = 1; r <= 8; r++) push_ev(r, r);
    check("fill_count", count, 8);
    push_ev(9, 9);
    push_ev(10, 10);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drops", drop_count, 2);
    drain(n);
    check("drain_n", n, 8);
    for (int i = 0; i < 8 && i < n; i++) check("drain_rd", got_rd[i], i + 1);
    for (int i = 1; i < 8 && i < n; i++) check("drain_ts_step", got_ts[i], got_ts[i-1] + 1);

    // 5: full with simultaneous push and pop
    for (int r = 1; r <= 8; r++) push_ev(r, r + 16);
    out_ready = 1'b1;
    push_ev(11, 8'hB1);
    out_ready = 1'b0;
    check("fullpp_count", count, 8);
    check("fullpp_drops", drop_count, 2);
    check("fullpp_head", out_rd, 2);
    drain(n);
    check("fullpp_n", n, 8);
    if (n == 8) check("fullpp_last", got_rd[7], 11);

    // 6a: clear collides with a drop
    for (int r = 1; r <= 8; r++) push_ev(r, r);
    clear_ovf = 1'b1;
    push_ev(12, 12);
    clear_ovf = 1'b0;
    check("clr_coll_ovf", overflow, 1'b1);
    check("clr_coll_drops", drop_count, 1);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    check("clr_ovf", overflow, 1'b0);
    check("clr_drops", drop_count, 0);

    // mid-operation reset discards contents
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_rd", out_rd, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    edge_idx = 0;
    push_ev(3, 8'h33);
    check("rst_ts_restart", out_ts, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 6b: timestamp wrap
    while (edge_idx < TS_MOD) tick();
    push_ev(13, 8'h5A);
    check("wrap_rd", out_rd, 13);
    check("wrap_ts", out_ts, 0);
    push_ev(14, 8'h5B);
    drain(n);
    check("wrap_n", n, 2);
    if (n == 2) check("wrap_ts_next", got_ts[1], 1);
    repeat (4500) tick();

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
